bus_src_encoder: RTL and testbench
==================================

Name: bus_src_encoder

Overview:
- Parametrised, registered successor to the 32-to-5 bus-source encoder in the datapath.
- Samples the one-hot "Xout" drive-enable vector (R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout, spares) and produces a registered bus-mux select with a valid flag.
- Adds source masking, fixed-priority or round-robin resolution, grant hold, and multi-hot fault detection with a sticky error flag.

Parameters:
- NUM_SRC, 32, number of request inputs; must be at least 2.
- SEL_W, 5, select width; must equal clog2(NUM_SRC).
- PRIO_MODE, 0, resolution mode: 0 = fixed priority (lowest index wins); 1 = round robin.
- REQ_MASK, all ones (NUM_SRC bits), bit = 0 means that input is permanently ignored (tied-off spares).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- req  in  NUM_SRC  drive-enable vector; bit i = source i requests the bus.
- hold  in  1  freeze current grant.
- err_clr  in  1  clear sticky error.
- sel  out  SEL_W  registered encoded index of granted source.
- valid  out  1  registered; sel is meaningful.
- multi_hot  out  1  registered; more than one masked request was sampled last cycle.
- err_sticky  out  1  set on any multi-hot sample; held until cleared.

Behaviour:
- Reset, sampled at the rising edge while reset = 1: sel = 0, valid = 0, multi_hot = 0, err_sticky = 0, round-robin pointer rr_ptr = 0. Reset overrides hold and err_clr.
- Effective request: mreq = req AND REQ_MASK. All decisions use mreq only.
- Latency: one cycle. mreq sampled at edge k appears on sel and valid after edge k.
- Mode 0: grant the lowest set index of mreq. rr_ptr is unused and stays 0.
- Mode 1:
  - Search mreq starting at index rr_ptr, ascending, wrapping from NUM_SRC-1 to 0.
  - Grant the first set bit g found.
  - Next rr_ptr = g+1, or 0 when g = NUM_SRC-1.
- mreq = 0 (and hold = 0): valid = 0. sel keeps its previous value (no glitch on the mux). rr_ptr does not change.
- Hold:
  - When hold = 1 and valid = 1: sel, valid and rr_ptr keep their values, whatever req is.
  - When hold = 1 and valid = 0: hold has no effect; normal grant applies.
- multi_hot: registered every cycle from popcount(mreq) > 1, independent of hold.
- err_sticky:
  - Next value = (err_sticky AND NOT err_clr) OR (popcount(mreq) > 1).
  - If err_clr and a multi-hot sample occur in the same cycle, set wins.
- A multi-hot vector is still resolved normally (priority or round robin) and valid = 1; multi-hot only raises flags.
- Reset asserted mid-hold or mid-rotation: all state returns to the reset values at that edge. The first grant after reset in mode 1 searches from index 0.
- No combinational path from any input to any output.

Decomposition:
- Shared package bus_enc_pkg:
  - PRIO_FIXED = 0 and PRIO_RR = 1 constants.
  - clog2 function.
  - Default mask constant for the current CPU source map (24 used sources, upper 8 spares).
- One natural combinational sub-module, rr_prio_search:
  - Inputs: mreq and start index.
  - Outputs: found flag and index.
  - Mode 0 instantiates it with start = 0.
- Counters, registers and flags stay in bus_src_encoder.

Test Plan:
- Mode 0, walking one: req = bit 0 through bit 10, one per cycle -> sel = 0..10, each one cycle later; valid = 1; multi_hot = 0 throughout.
- Mode 0, multi-hot: req = bits 3 and 7 -> sel = 3, valid = 1, multi_hot = 1, err_sticky = 1. Then err_clr = 1 with req = bit 5 only -> err_sticky = 0. err_clr together with a multi-hot req -> err_sticky stays 1.
- Mode 1, rotation: req = all ones for 34 cycles -> sel = 0,1,...,31,0,1.
- Mode 1, wrap: req = bits 0 and 31 constantly -> sel alternates 0,31,0,31.
- Hold and empty: grant sel = 9; hold = 1 while req changes to bit 2 -> sel stays 9, valid stays 1. Release hold with req = 0 -> valid = 0, sel stays 9.
- Mask and reset: REQ_MASK = 0x00FFFFFF, req = bit 24 only -> valid = 0, multi_hot = 0. Reset pulse during a mode-1 rotation (sel = 12) -> all outputs 0; next all-ones req -> sel = 0.

Source files
------------

// File: rtl/bus_src_encoder_pkg.sv
// Shared constants and helpers for the bus-source encoder slice.
// Defines the resolution-mode encodings and the CPU's default source map.
package bus_enc_pkg;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort and C are live; the top 8 are spares.
  localparam logic [31:0] CPU_SRC_MASK = 32'h00FF_FFFF;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_src_encoder_rr_prio_search.sv
// Circular priority search: the first set request at or after start_i,
// wrapping from the top index back to zero.
module rr_prio_search
  import bus_enc_pkg::*;
#(
  parameter int NUM_SRC = 32,
  parameter int SEL_W   = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] mreq_i,
  input  logic [SEL_W-1:0]   start_i,
  output logic               found_o,
  output logic [SEL_W-1:0]   idx_o
);

  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    pos     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, start_i} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(NUM_SRC)) sum = sum - (SEL_W+1)'(NUM_SRC);
      pos = sum[SEL_W-1:0];
      if (!found_o && mreq_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/bus_src_encoder.sv
// Registered bus-source encoder: masks the one-hot drive-enable vector, resolves
// it by fixed priority or round robin, and flags multi-hot samples.
module bus_src_encoder
  import bus_enc_pkg::*;
#(
  parameter int                 NUM_SRC   = 32,
  parameter int                 SEL_W     = clog2(NUM_SRC),
  parameter int                 PRIO_MODE = PRIO_FIXED,
  parameter logic [NUM_SRC-1:0] REQ_MASK  = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               hold,
  input  logic               err_clr,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               multi_hot,
  output logic               err_sticky
);

  logic [NUM_SRC-1:0] mreq;
  logic [SEL_W-1:0]   startIdx;
  logic               found;
  logic [SEL_W-1:0]   foundIdx;

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rrPtr_q, rrPtr_d;
  logic             valid_q, valid_d;
  logic             multiHot_q, multiHot_d;
  logic             errSticky_q, errSticky_d;

  assign mreq     = req & REQ_MASK;
  assign startIdx = (PRIO_MODE == PRIO_RR) ? rrPtr_q : '0;

  rr_prio_search #(
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_search (
    .mreq_i (mreq),
    .start_i(startIdx),
    .found_o(found),
    .idx_o  (foundIdx)
  );

  // An idle cycle drops valid but leaves sel parked so the bus mux never glitches.
  always_comb begin
    sel_d       = sel_q;
    valid_d     = valid_q;
    rrPtr_d     = rrPtr_q;
    multiHot_d  = |(mreq & (mreq - NUM_SRC'(1)));
    errSticky_d = (errSticky_q & ~err_clr) | multiHot_d;
    if (!(hold && valid_q)) begin
      if (found) begin
        sel_d   = foundIdx;
        valid_d = 1'b1;
        if (PRIO_MODE == PRIO_RR) begin
          rrPtr_d = (foundIdx == SEL_W'(NUM_SRC - 1)) ? '0 : foundIdx + SEL_W'(1);
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= '0;
      rrPtr_q     <= '0;
      valid_q     <= 1'b0;
      multiHot_q  <= 1'b0;
      errSticky_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      rrPtr_q     <= rrPtr_d;
      valid_q     <= valid_d;
      multiHot_q  <= multiHot_d;
      errSticky_q <= errSticky_d;
    end
  end

  assign sel        = sel_q;
  assign valid      = valid_q;
  assign multi_hot  = multiHot_q;
  assign err_sticky = errSticky_q;

endmodule

// File: tb/tb_bus_src_encoder.sv
// Directed scoreboard bench for bus_src_encoder: fixed-priority, round-robin and
// masked instances share one stimulus stream; expectations are queued per step.
module tb_bus_src_encoder;
  import bus_enc_pkg::*;

  typedef struct {
    string      tag;
    int         dutId;
    logic [4:0] sel;
    logic       valid;
    logic       mh;
    logic       err;
    bit         careSel;
    bit         careErr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req;
  logic        hold;
  logic        errClr;

  logic [4:0] selO       [3];
  logic       validO     [3];
  logic       multiHotO  [3];
  logic       errStickyO [3];

  exp_t sbQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  bus_src_encoder #(.NUM_SRC(32), .SEL_W(5), .PRIO_MODE(PRIO_FIXED), .REQ_MASK('1)) dutFixed (
    .clk(clk), .reset(reset), .req(req), .hold(hold), .err_clr(errClr),
    .sel(selO[0]), .valid(validO[0]), .multi_hot(multiHotO[0]), .err_sticky(errStickyO[0])
  );

  bus_src_encoder #(.NUM_SRC(32), .SEL_W(5), .PRIO_MODE(PRIO_RR), .REQ_MASK('1)) dutRr (
    .clk(clk), .reset(reset), .req(req), .hold(hold), .err_clr(errClr),
    .sel(selO[1]), .valid(validO[1]), .multi_hot(multiHotO[1]), .err_sticky(errStickyO[1])
  );

  bus_src_encoder #(.NUM_SRC(32), .SEL_W(5), .PRIO_MODE(PRIO_RR), .REQ_MASK(CPU_SRC_MASK)) dutMasked (
    .clk(clk), .reset(reset), .req(req), .hold(hold), .err_clr(errClr),
    .sel(selO[2]), .valid(validO[2]), .multi_hot(multiHotO[2]), .err_sticky(errStickyO[2])
  );

  // Inputs change on the falling edge so the rising edge sees them settled.
  task automatic applyStimulus(input logic [31:0] r, input logic h, input logic c, input logic rs);
    @(negedge clk);
    req    = r;
    hold   = h;
    errClr = c;
    reset  = rs;
  endtask

  task automatic pushExp(input string tag, input int d, input logic [4:0] s, input logic v,
                         input logic m, input logic e, input bit cs = 1'b1, input bit ce = 1'b1);
    exp_t x;
    x.tag = tag; x.dutId = d; x.sel = s; x.valid = v; x.mh = m; x.err = e;
    x.careSel = cs; x.careErr = ce;
    sbQ.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      if (e.careSel) begin
        testsRun++;
        assert (selO[e.dutId] === e.sel) else begin
          testsFailed++;
          $error("[TB] FAIL %s dut%0d sel: observed %0d expected %0d", e.tag, e.dutId, selO[e.dutId], e.sel);
        end
      end
      testsRun++;
      assert (validO[e.dutId] === e.valid) else begin
        testsFailed++;
        $error("[TB] FAIL %s dut%0d valid: observed %0b expected %0b", e.tag, e.dutId, validO[e.dutId], e.valid);
      end
      testsRun++;
      assert (multiHotO[e.dutId] === e.mh) else begin
        testsFailed++;
        $error("[TB] FAIL %s dut%0d multi_hot: observed %0b expected %0b", e.tag, e.dutId, multiHotO[e.dutId], e.mh);
      end
      if (e.careErr) begin
        testsRun++;
        assert (errStickyO[e.dutId] === e.err) else begin
          testsFailed++;
          $error("[TB] FAIL %s dut%0d err_sticky: observed %0b expected %0b", e.tag, e.dutId, errStickyO[e.dutId], e.err);
        end
      end
    end
  endtask

  task automatic resetAll(input string tag, input logic [31:0] r);
    applyStimulus(r, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 3; d++) pushExp(tag, d, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput();
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    hold   = 1'b0;
    errClr = 1'b0;

    resetAll("reset", 32'h0);

    // Mode 0 walking one
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(32'h1 << i, 1'b0, 1'b0, 1'b0);
      pushExp($sformatf("walk%0d", i), 0, 5'(i), 1'b1, 1'b0, 1'b0);
      checkOutput();
    end

    // Mode 0 multi-hot and sticky error clearing
    applyStimulus((32'h1 << 3) | (32'h1 << 7), 1'b0, 1'b0, 1'b0);
    pushExp("mh3_7", 0, 5'd3, 1'b1, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(32'h1 << 5, 1'b0, 1'b1, 1'b0);
    pushExp("clr", 0, 5'd5, 1'b1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus((32'h1 << 1) | (32'h1 << 2), 1'b0, 1'b1, 1'b0);
    pushExp("clrVsSet", 0, 5'd1, 1'b1, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(32'h1 << 4, 1'b0, 1'b0, 1'b0);
    pushExp("stickyHeld", 0, 5'd4, 1'b1, 1'b0, 1'b1);
    checkOutput();
    applyStimulus(32'h1 << 4, 1'b0, 1'b1, 1'b0);
    pushExp("clr2", 0, 5'd4, 1'b1, 1'b0, 1'b0);
    checkOutput();

    // Hold and empty request
    applyStimulus(32'h1 << 9, 1'b0, 1'b0, 1'b0);
    pushExp("grant9", 0, 5'd9, 1'b1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus(32'h1 << 2, 1'b1, 1'b0, 1'b0);
    pushExp("hold9", 0, 5'd9, 1'b1, 1'b0, 1'b0);
    checkOutput();
    applyStimulus((32'h1 << 2) | (32'h1 << 4), 1'b1, 1'b0, 1'b0);
    pushExp("holdMh", 0, 5'd9, 1'b1, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    pushExp("empty", 0, 5'd9, 1'b0, 1'b0, 1'b1);
    checkOutput();
    applyStimulus(32'h1 << 6, 1'b1, 1'b0, 1'b0);
    pushExp("holdNoValid", 0, 5'd6, 1'b1, 1'b0, 1'b1);
    checkOutput();
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    pushExp("emptyClr", 0, 5'd6, 1'b0, 1'b0, 1'b0);
    checkOutput();

    // Mode 1 rotation across the wrap point
    resetAll("resetRot", 32'h0);
    for (int i = 0; i < 34; i++) begin
      applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      pushExp($sformatf("rot%0d", i), 1, 5'(i % 32), 1'b1, 1'b1, 1'b1);
      checkOutput();
    end

    // Mode 1 alternating between the two ends
    resetAll("resetWrap", 32'h0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h8000_0001, 1'b0, 1'b0, 1'b0);
      pushExp($sformatf("wrap%0d", i), 1, (i % 2 == 0) ? 5'd0 : 5'd31, 1'b1, 1'b1, 1'b1);
      checkOutput();
    end

    // Masked spares and reset during rotation
    resetAll("resetMask", 32'h0);
    applyStimulus(32'h1 << 24, 1'b0, 1'b0, 1'b0);
    pushExp("spare24", 2, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    applyStimulus((32'h1 << 24) | (32'h1 << 3), 1'b0, 1'b0, 1'b0);
    pushExp("spareMasked", 2, 5'd3, 1'b1, 1'b0, 1'b0);
    checkOutput();
    resetAll("resetMask2", 32'h0);
    for (int i = 0; i <= 12; i++) begin
      applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      pushExp($sformatf("mrot%0d", i), 2, 5'(i), 1'b1, 1'b1, 1'b1);
      checkOutput();
    end
    resetAll("midRotReset", 32'hFFFF_FFFF);
    applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    pushExp("afterReset0", 2, 5'd0, 1'b1, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    pushExp("afterReset1", 2, 5'd1, 1'b1, 1'b1, 1'b1);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
